// File: rtl/coeff_tile_streamer_pkg.sv
// Shared definitions for the polynomial-multiplier coefficient path.
// Holds the streamer state encoding and the tile-count / index-width helpers
// used to size ports and counters consistently across files.
package coeff_tile_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } stream_state_e;

  // Number of tiles that make up one polynomial.
  function automatic int num_tiles(input int degree_n, input int tile_width);
    return degree_n / tile_width;
  endfunction

  // Width of an index over n items; never narrower than one bit so that a
  // single-item range still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coeff_tile_streamer_coeff_buffer.sv
// coeff_buffer: DEGREE_N x DATA_WIDTH coefficient store.
// One synchronous write port, one combinational TILE_WIDTH-wide read port
// starting at base_i. Contents clear to zero on reset.
//   clk, rst      : clock, asynchronous active-low reset
//   wr_en_i       : write strobe (already qualified by the caller)
//   wr_addr_i     : coefficient index to write
//   wr_data_i     : coefficient value
//   base_i        : first coefficient index of the tile to read
//   rd_tile_o     : element k = mem[base_i + k]
module coeff_buffer
  import coeff_tile_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int TILE_WIDTH = 4,
  localparam int AW        = idx_width(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en_i,
  input  logic [AW-1:0]                         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]                 wr_data_i,
  input  logic [AW-1:0]                         base_i,
  output logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] rd_tile_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_tile_o = '0;
    for (int k = 0; k < TILE_WIDTH; k++) begin
      rd_tile_o[k] = mem_q[base_i + AW'(k)];
    end
  end

endmodule

// File: rtl/coeff_tile_streamer.sv
// coeff_tile_streamer: loads a polynomial's coefficients while idle, then on
// start_i replays it NUM_PASSES times as TILE_WIDTH-wide tiles.
//   clk, rst        : clock, asynchronous active-low reset
//   wr_en_i/addr/data : coefficient load port, honoured only in IDLE
//   start_i         : one-cycle pulse, begins streaming from IDLE
//   ready_i         : consumer accept
//   valid_o         : tile on coeff_o is valid
//   coeff_o         : tile, element k = buffer[base+k]
//   tile_idx_o      : index of presented tile within the polynomial
//   last_o          : presented tile is the final tile of the final pass
//   busy_o          : high outside IDLE
//   done_o          : one-cycle pulse after the final tile is accepted
//   state_o         : current FSM state for observation
//
// Handshake: a tile transfers on a rising edge where valid_o && ready_i.
// While valid_o is high, coeff_o/tile_idx_o/last_o hold until that transfer;
// ready_i has no effect while valid_o is low.
module coeff_tile_streamer
  import coeff_tile_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEGREE_N   = 16,
  parameter int TILE_WIDTH = 4,
  parameter int NUM_PASSES = 1,
  localparam int AW        = idx_width(DEGREE_N),
  localparam int NT        = num_tiles(DEGREE_N, TILE_WIDTH),
  localparam int TIDX_W    = idx_width(NT),
  localparam int PASS_W    = idx_width(NUM_PASSES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en_i,
  input  logic [AW-1:0]                         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]                 wr_data_i,
  input  logic                                  start_i,
  input  logic                                  ready_i,
  output logic                                  valid_o,
  output logic [TILE_WIDTH-1:0][DATA_WIDTH-1:0] coeff_o,
  output logic [TIDX_W-1:0]                     tile_idx_o,
  output logic                                  last_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output stream_state_e                         state_o
);

  stream_state_e     state_q, state_d;
  logic [TIDX_W-1:0] tile_q, tile_d;
  logic [PASS_W-1:0] pass_q, pass_d;

  logic hs;
  logic final_tile;
  logic final_pass;
  logic [AW-1:0] base;

  assign hs         = (state_q == ST_STREAM) && ready_i;
  assign final_tile = (tile_q == TIDX_W'(NT - 1));
  assign final_pass = (pass_q == PASS_W'(NUM_PASSES - 1));
  // Tile index is kept instead of a coefficient base so wrap is a compare
  // against the tile count; the base is derived for the buffer read.
  assign base       = AW'(int'(tile_q) * TILE_WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tile_q  <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_STREAM;
          tile_d  = '0;
          pass_d  = '0;
        end
      end
      ST_STREAM: begin
        if (hs) begin
          if (final_tile && final_pass) begin
            state_d = ST_DONE;
            tile_d  = '0;
            pass_d  = '0;
          end else if (final_tile) begin
            tile_d = '0;
            pass_d = pass_q + PASS_W'(1);
          end else begin
            tile_d = tile_q + TIDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer is frozen outside IDLE; a write coincident with start still lands
  // because the state is IDLE on that edge, so tile 0 sees it.
  coeff_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEGREE_N),
    .TILE_WIDTH(TILE_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_en_i && (state_q == ST_IDLE)),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .base_i   (base),
    .rd_tile_o(coeff_o)
  );

  assign valid_o    = (state_q == ST_STREAM);
  assign last_o     = valid_o && final_tile && final_pass;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign tile_idx_o = tile_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_coeff_tile_streamer.sv
// Bench for coeff_tile_streamer: two instances (one pass, two passes) share
// the same stimulus; a per-instance reference model predicts every output.
module tb_coeff_tile_streamer;
  import coeff_tile_streamer_pkg::*;

  localparam int DW = 64;
  localparam int DN = 16;
  localparam int TW = 4;
  localparam int NT = DN / TW;

  typedef logic [TW-1:0][DW-1:0] tile_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en   = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start   = 1'b0;
  logic          ready   = 1'b0;

  logic valid0, last0, busy0, done0;
  logic valid1, last1, busy1, done1;
  tile_t coeff0, coeff1;
  logic [1:0] idx0, idx1;
  stream_state_e st0, st1;

  coeff_tile_streamer #(.DATA_WIDTH(DW), .DEGREE_N(DN), .TILE_WIDTH(TW), .NUM_PASSES(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_i(start), .ready_i(ready), .valid_o(valid0), .coeff_o(coeff0),
    .tile_idx_o(idx0), .last_o(last0), .busy_o(busy0), .done_o(done0), .state_o(st0)
  );

  coeff_tile_streamer #(.DATA_WIDTH(DW), .DEGREE_N(DN), .TILE_WIDTH(TW), .NUM_PASSES(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_i(start), .ready_i(ready), .valid_o(valid1), .coeff_o(coeff1),
    .tile_idx_o(idx1), .last_o(last1), .busy_o(busy1), .done_o(done1), .state_o(st1)
  );

  // ---------------- reference model ----------------
  // Per instance: buffer contents, the frozen copy taken at start, how many
  // tiles have been accepted out of the total, and a pending done pulse.
  logic [DW-1:0] mem_m  [2][DN];
  logic [DW-1:0] snap_m [2][DN];
  bit            act    [2];
  bit            dn     [2];
  int            sent   [2];
  int            total  [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i]  = 1'b0;
      dn[i]   = 1'b0;
      sent[i] = 0;
      for (int a = 0; a < DN; a++) begin
        mem_m[i][a]  = '0;
        snap_m[i][a] = '0;
      end
    end
  endtask

  // Compare this cycle's outputs, then apply this cycle's inputs to the model.
  task automatic check_and_advance();
    for (int i = 0; i < 2; i++) begin
      logic ov, ol, ob, od;
      logic [1:0] oi;
      tile_t ot, et;
      bit idle, nd;
      int t;
      ov = (i == 0) ? valid0 : valid1;
      ol = (i == 0) ? last0  : last1;
      ob = (i == 0) ? busy0  : busy1;
      od = (i == 0) ? done0  : done1;
      oi = (i == 0) ? idx0   : idx1;
      ot = (i == 0) ? coeff0 : coeff1;
      chk($sformatf("valid%0d", i), ov, act[i]);
      chk($sformatf("busy%0d", i), ob, act[i] || dn[i]);
      chk($sformatf("done%0d", i), od, dn[i]);
      chk($sformatf("last%0d", i), ol, act[i] && (sent[i] == total[i] - 1));
      if (act[i]) begin
        t = sent[i] % NT;
        for (int k = 0; k < TW; k++) et[k] = snap_m[i][t * TW + k];
        chk($sformatf("coeff%0d_n%0d", i, sent[i]), ot, et);
        chk($sformatf("idx%0d_n%0d", i, sent[i]), oi, t);
      end
      idle = !act[i] && !dn[i];
      nd   = 1'b0;
      if (act[i] && ready) begin
        sent[i]++;
        if (sent[i] == total[i]) begin
          act[i] = 1'b0;
          nd     = 1'b1;
        end
      end
      if (idle && wr_en) mem_m[i][wr_addr] = wr_data;
      if (idle && start) begin
        act[i]  = 1'b1;
        sent[i] = 0;
        for (int a = 0; a < DN; a++) snap_m[i][a] = mem_m[i][a];
      end
      dn[i] = nd;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input int a, input logic [DW-1:0] d,
                       input bit s, input bit r);
    wr_en   = w;
    wr_addr = 4'(a);
    wr_data = d;
    start   = s;
    ready   = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid0"}, valid0, 1'b0);
    chk({tag, "_valid1"}, valid1, 1'b0);
    chk({tag, "_busy0"}, busy0, 1'b0);
    chk({tag, "_done1"}, done1, 1'b0);
    chk({tag, "_last1"}, last1, 1'b0);
    chk({tag, "_idx1"}, idx1, 2'd0);
    chk({tag, "_coeff0"}, coeff0, '0);
    chk({tag, "_coeff1"}, coeff1, '0);
    chk({tag, "_state0"}, st0, ST_IDLE);
    chk({tag, "_state1"}, st1, ST_IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    total[0] = NT * 1;
    total[1] = NT * 2;
    model_reset();

    // Reset state.
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Load buffer[i] = i+1; the last write coincides with start.
    for (int i = 0; i < DN - 1; i++) begin
      drive(1, i, DW'(i + 1), 0, 0);
      step();
    end
    drive(1, DN - 1, DW'(DN), 1, 1);
    step();
    drive(0, 0, '0, 0, 1);
    repeat (14) step();

    // Same load, ready pulsed every 5th cycle; write and restart attempts
    // while streaming must be ignored.
    drive(0, 0, '0, 1, 0);
    step();
    for (int c = 0; c < 50; c++) begin
      drive(c == 2, 5, 64'hDEAD, c == 7 || c == 23, (c % 5) == 4);
      step();
    end

    // Randomized rounds: random load, then random ready/start/writes.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DN; i++) begin
        drive(1, i, {$urandom, $urandom}, 0, $urandom_range(0, 1));
        step();
      end
      drive(0, 0, '0, 1, $urandom_range(0, 1));
      step();
      for (int c = 0; c < 40; c++) begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, DN - 1), {$urandom, $urandom},
              $urandom_range(0, 7) == 0, $urandom_range(0, 1));
        step();
      end
      drive(0, 0, '0, 0, 1);
      repeat (20) step();
    end

    // Reset mid-stream after the second handshake.
    for (int i = 0; i < DN; i++) begin
      drive(1, i, DW'(i + 1), 0, 0);
      step();
    end
    drive(0, 0, '0, 1, 1);
    step();
    drive(0, 0, '0, 0, 1);
    for (int c = 0; c < 10 && sent[0] < 2; c++) step();
    rst = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 0, '0, 0, 1);
    repeat (4) step();
    // Restart without loading: buffer must read back as zero.
    drive(0, 0, '0, 1, 1);
    step();
    drive(0, 0, '0, 0, 1);
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
